// File: rtl/frame_stream_capture.sv
// frame_stream_capture
// Watches a pixel stream, counts frames, records a window of frames
// (START_FRAME..STOP_FRAME) and presents each recorded pixel as a 24-bit RGB
// beat, tagged with start-of-frame / end-of-line / end-of-frame, on a
// valid/ready stream through a first-word-fall-through FIFO.
module frame_stream_capture #(
    parameter int IMAGE_W     = 256,
    parameter int IMAGE_H     = 240,
    parameter int PIX_W       = 8,
    parameter int START_FRAME = 0,
    parameter int STOP_FRAME  = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int PAL_MODE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pixel,
    input  logic             pixel_en,
    input  logic             frame,
    input  logic             pal_we,
    input  logic [5:0]       pal_addr,
    input  logic [23:0]      pal_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [23:0]      m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic [15:0]      frame_cnt,
    output logic             record_en,
    output logic             done,
    output logic             overflow,
    output logic             size_err
);

    // ------------------------------------------------------------------
    // Geometry and sizing
    // ------------------------------------------------------------------
    localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    // y must be able to hold IMAGE_H itself: that value means "frame complete".
    localparam int YW = $clog2(IMAGE_H + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_H - 1);
    localparam logic [YW-1:0] Y_END    = YW'(IMAGE_H);
    localparam logic [16:0]   START_17 = 17'(START_FRAME);
    localparam logic [16:0]   STOP_17  = 17'(STOP_FRAME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } entry_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t          state, state_nxt;
    logic            frame_r;
    logic            new_frame;
    logic [15:0]     cnt_nxt;
    logic [15:0]     cnt_inc;
    logic            past_stop;
    logic            reach_start;

    logic [XW-1:0]   x, x_nxt, cur_x;
    logic [YW-1:0]   y, y_nxt, cur_y;
    logic            capture;
    logic            in_frame;
    logic            push_req;
    logic            late_pixel;
    logic            short_frame;
    entry_t          push_entry;

    logic [23:0]     pal_mem [64];

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    entry_t          head;

    // ------------------------------------------------------------------
    // Frame marker edge detection
    // ------------------------------------------------------------------
    // Register the marker and turn its rising edge into a one-cycle pulse.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r   <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            frame_r   <= frame;
            new_frame <= frame & ~frame_r;
        end
    end

    // ------------------------------------------------------------------
    // Recording state machine and frame counter
    // ------------------------------------------------------------------
    // The counter saturates instead of wrapping back into the window.
    assign cnt_inc     = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
    // "x + 1 > N" is "x >= N" written so a zero threshold stays a live compare.
    assign past_stop   = ({1'b0, frame_cnt} + 17'd1) > STOP_17;
    assign reach_start = ({1'b0, cnt_inc} + 17'd1) > START_17;

    // State and frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= cnt_nxt;
        end
    end

    // Next-state decision, taken only on a new frame pulse.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = frame_cnt;
        if (new_frame && state != DONE) begin
            if (state == RECORD && past_stop) begin
                state_nxt = DONE;
            end else begin
                cnt_nxt   = cnt_inc;
                state_nxt = reach_start ? RECORD : SKIP;
            end
        end
    end

    assign record_en = (state == RECORD);

    // ------------------------------------------------------------------
    // Pixel position, tagging and push request
    // ------------------------------------------------------------------
    // A pixel arriving with the new-frame pulse is pixel (0,0) of the new
    // frame and belongs to whatever state that frame is entering.
    always_comb begin
        capture     = new_frame ? (state_nxt == RECORD) : (state == RECORD);
        cur_x       = new_frame ? '0 : x;
        cur_y       = new_frame ? '0 : y;
        in_frame    = (cur_y != Y_END);
        push_req    = pixel_en && capture && in_frame;
        late_pixel  = pixel_en && capture && !in_frame;
        short_frame = new_frame && (state == RECORD) && (y != Y_END);

        push_entry.data = (PAL_MODE != 0) ? pal_mem[pixel[5:0]] : 24'(pixel);
        push_entry.sof  = (cur_x == '0) && (cur_y == '0);
        push_entry.eol  = (cur_x == X_LAST);
        push_entry.eof  = (cur_x == X_LAST) && (cur_y == Y_LAST);

        x_nxt = cur_x;
        y_nxt = cur_y;
        // Position advances even when the FIFO drops the pixel.
        if (push_req) begin
            if (cur_x == X_LAST) begin
                x_nxt = '0;
                y_nxt = cur_y + YW'(1);
            end else begin
                x_nxt = cur_x + XW'(1);
            end
        end
    end

    // Column / line counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Palette
    // ------------------------------------------------------------------
    // Palette write port; the combinational read above sees the old entry
    // in the cycle it is being overwritten.
    // NOTE: storage arrays carry no reset so they map onto plain RAM; only
    // the control state around them is reset.
    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_data;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && m_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // FIFO pointers; reset empties the buffer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Head of the FIFO drives the stream; masked to zero while empty so
    // stale storage never shows on the outputs.
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? 24'd0 : head.data;
    assign m_sof   = !fifo_empty && head.sof;
    assign m_eol   = !fifo_empty && head.eol;
    assign m_eof   = !fifo_empty && head.eof;
    assign done    = (state == DONE) && fifo_empty;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    // Overflow: dropped push. Size error: pixel past eof, or a recorded
    // frame closed before all IMAGE_W*IMAGE_H pixels arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            size_err <= 1'b0;
        end else begin
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (late_pixel || short_frame) begin
                size_err <= 1'b1;
            end
        end
    end

endmodule
